// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the 4-digit multiplexed 7-segment scanner
// controller (disp_scan_ctrl) and its segment encoder (seg7_enc).
//   state_t     : controller state, base display or timed overlay
//   SEG_BLANK   : active-low byte with every segment and the DP dark
//   DP_BIT      : position of the decimal point in a segment byte
//   GLYPH_TABLE : active-low {DP,G,F,E,D,C,B,A} for digits 0-9 and A b C d E F,
//                 with the DP bit held dark (1)
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [0:0] {
        S_BASE = 1'b0,
        S_OVR  = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

    // Entry n sits at GLYPH_TABLE[n]; the list reads from F down to 0.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/disp_scan_ctrl_seg7_enc.sv
// -----------------------------------------------------------------------------
// seg7_enc
// Combinational BCD/hex digit to active-low 7-segment byte encoder.
//   digit : 4-bit value, 0-9 as numerals, 10-15 as A b C d E F
//   dp    : 1 lights the decimal point (clears bit 7)
//   seg   : {DP,G,F,E,D,C,B,A}, active-low
// -----------------------------------------------------------------------------
module seg7_enc
    import disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg         = GLYPH_TABLE[digit];
        seg[DP_BIT] = ~dp;
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
// Controller for the DCOUNT 4-digit multiplexed 7-segment scanner. Produces
// the scan tick for the mux, arbitrates between the base counter display and
// a timed overlay, and drives registered active-low segment bytes.
//
// Parameters
//   SCAN_DIV   : CLK cycles per ENABLE pulse (>= 2)
//   BLINK_DIV  : ENABLE pulses per blink half-period (>= 1)
//   HOLD_TICKS : blink half-periods an overlay stays up (>= 1)
//
// Ports
//   CLK, RST_N    : clock, asynchronous active-low reset
//   BASE_BCD/DP   : base digits and decimal points, [15:12]/[3] is L1 (left)
//   BLINK_MASK    : base digits that blink, [3] is L1
//   OVR_REQ/BCD   : overlay request and data (data captured on accept)
//   OVR_ACK       : one-cycle pulse per accepted request
//   OVR_BUSY      : high while the overlay is displayed
//   ENABLE        : one-cycle scan tick
//   L1..L4        : segment bytes {DP,G,F,E,D,C,B,A}, active-low
//
// Build option
//   LZ_BLANK_EN   : when defined, leading zeros of L1..L3 with DP off are
//                   blanked on the base display; L4 always shows.
// -----------------------------------------------------------------------------
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64,
    parameter int HOLD_TICKS = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] BASE_BCD,
    input  logic [3:0]  BASE_DP,
    input  logic [3:0]  BLINK_MASK,
    input  logic        OVR_REQ,
    input  logic [15:0] OVR_BCD,
    output logic        OVR_ACK,
    output logic        OVR_BUSY,
    output logic        ENABLE,
    output logic [7:0]  L1,
    output logic [7:0]  L2,
    output logic [7:0]  L3,
    output logic [7:0]  L4
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               enable_q, enable_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               blink_tick;
    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [15:0]        ovr_bcd_q, ovr_bcd_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [3:0][7:0]    seg_q, seg_d;

    logic               ovr_active;
    logic [3:0][3:0]    enc_digit;
    logic [3:0]         enc_dp;
    logic [3:0][7:0]    enc_seg;
    logic [3:0]         lz_blank;

    // Timing and overlay arbitration.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        presc_d = (presc_q == PRESC_W'(SCAN_DIV - 1)) ? '0 : presc_q + 1'b1;
        enable_d = (presc_q == PRESC_W'(SCAN_DIV - 1));

        // blink_tick marks the ENABLE that wraps the blink counter.
        blink_tick    = enable_q && (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d   = blink_cnt_q;
        if (enable_q) begin
            blink_cnt_d = blink_tick ? '0 : blink_cnt_q + 1'b1;
        end
        blink_phase_d = blink_phase_q ^ blink_tick;

        state_d   = state_q;
        hold_d    = hold_q;
        ovr_bcd_d = ovr_bcd_q;
        ack_d     = 1'b0;
        // A request outranks both the hold countdown and expiry.
        if (OVR_REQ) begin
            state_d   = S_OVR;
            hold_d    = HOLD_W'(HOLD_TICKS);
            ovr_bcd_d = OVR_BCD;
            ack_d     = 1'b1;
        end else if (state_q == S_OVR) begin
            if (hold_q == '0) begin
                state_d = S_BASE;
            end else if (blink_tick) begin
                hold_d = hold_q - 1'b1;
            end
        end
        // Registered from the next state so BUSY falls with the state change.
        busy_d = (state_d == S_OVR);
    end

    // Source select feeding the four encoders.
    assign ovr_active = (state_q == S_OVR);

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            enc_digit[p] = ovr_active ? ovr_bcd_q[4*p +: 4] : BASE_BCD[4*p +: 4];
            enc_dp[p]    = !ovr_active && BASE_DP[p];
        end
    end

    for (genvar p = 0; p < 4; p++) begin : g_enc
        seg7_enc u_seg7_enc (
            .digit (enc_digit[p]),
            .dp    (enc_dp[p]),
            .seg   (enc_seg[p])
        );
    end

    // Blink and leading-zero blanking apply to the base display only.
    always_comb begin
        lz_blank = '0;
`ifdef LZ_BLANK_EN
        // The blank run starts at L1 and stops at the first nonzero digit or lit DP.
        lz_blank[3] = (BASE_BCD[15:12] == 4'd0) && !BASE_DP[3];
        lz_blank[2] = lz_blank[3] && (BASE_BCD[11:8] == 4'd0) && !BASE_DP[2];
        lz_blank[1] = lz_blank[2] && (BASE_BCD[7:4] == 4'd0) && !BASE_DP[1];
`endif
        for (int p = 0; p < 4; p++) begin
            seg_d[p] = enc_seg[p];
            if (!ovr_active && ((BLINK_MASK[p] && blink_phase_q) || lz_blank[p])) begin
                seg_d[p] = SEG_BLANK;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q       <= '0;
            enable_q      <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            state_q       <= S_BASE;
            hold_q        <= '0;
            ovr_bcd_q     <= '0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            seg_q         <= {4{SEG_BLANK}};
        end else begin
            presc_q       <= presc_d;
            enable_q      <= enable_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            hold_q        <= hold_d;
            ovr_bcd_q     <= ovr_bcd_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            seg_q         <= seg_d;
        end
    end

    assign ENABLE   = enable_q;
    assign OVR_ACK  = ack_q;
    assign OVR_BUSY = busy_q;
    assign L1       = seg_q[3];
    assign L2       = seg_q[2];
    assign L3       = seg_q[1];
    assign L4       = seg_q[0];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_ctrl
// Directed bench for disp_scan_ctrl with SCAN_DIV=4, BLINK_DIV=2, HOLD_TICKS=3.
// Expected display/handshake values are queued with the cycle (edges since
// reset release) at which they must appear and compared at the falling edge.
// ENABLE is compared every cycle against its pulse schedule.
// -----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    localparam int SCAN_DIV   = 4;
    localparam int BLINK_DIV  = 2;
    localparam int HOLD_TICKS = 3;
    localparam int HALF       = SCAN_DIV * BLINK_DIV;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] BASE_BCD;
    logic [3:0]  BASE_DP;
    logic [3:0]  BLINK_MASK;
    logic        OVR_REQ;
    logic [15:0] OVR_BCD;
    logic        OVR_ACK;
    logic        OVR_BUSY;
    logic        ENABLE;
    logic [7:0]  L1, L2, L3, L4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] l;
        logic        busy;
        logic        ack;
    } exp_t;

    exp_t sb[$];

    disp_scan_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_DIV  (BLINK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .BASE_BCD   (BASE_BCD),
        .BASE_DP    (BASE_DP),
        .BLINK_MASK (BLINK_MASK),
        .OVR_REQ    (OVR_REQ),
        .OVR_BCD    (OVR_BCD),
        .OVR_ACK    (OVR_ACK),
        .OVR_BUSY   (OVR_BUSY),
        .ENABLE     (ENABLE),
        .L1         (L1),
        .L2         (L2),
        .L3         (L3),
        .L4         (L4)
    );

    always #5 CLK = ~CLK;

    // Rising edges since the last reset release.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [7:0] glyph(input logic [3:0] d, input logic dp);
        logic [7:0] g;
        case (d)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return dp ? (g & 8'h7F) : g;
    endfunction

    // Blink-blanked phase as seen on L at cycle n: first toggle lands HALF+1
    // edges after release and reaches L one edge later.
    function automatic bit phase_vis(input int n);
        return (n >= 2) && ((((n - 2) / HALF) % 2) == 1);
    endfunction

    function automatic logic [31:0] base_exp(input logic [15:0] bcd, input logic [3:0] dp,
                                             input logic [3:0] mask, input bit phase);
        logic [31:0] r;
        logic [7:0]  s;
`ifdef LZ_BLANK_EN
        bit lead;
        lead = 1'b1;
`endif
        r = '0;
        for (int p = 3; p >= 0; p--) begin
            s = glyph(bcd[4*p +: 4], dp[p]);
            if (mask[p] && phase) s = 8'hFF;
`ifdef LZ_BLANK_EN
            if (p > 0 && lead && bcd[4*p +: 4] == 4'd0 && !dp[p]) s = 8'hFF;
            else lead = 1'b0;
`endif
            r[8*p +: 8] = s;
        end
        return r;
    endfunction

    function automatic logic [31:0] ovr_exp(input logic [15:0] bcd);
        return {glyph(bcd[15:12], 1'b0), glyph(bcd[11:8], 1'b0),
                glyph(bcd[7:4], 1'b0), glyph(bcd[3:0], 1'b0)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [31:0] l,
                             input logic busy, input logic ack);
        exp_t e;
        e.cyc  = c;
        e.tag  = tag;
        e.l    = l;
        e.busy = busy;
        e.ack  = ack;
        sb.push_back(e);
    endtask

    // Advance to cycle c, checking ENABLE and due scoreboard entries each cycle.
    task automatic tick_to(input int c);
        exp_t e;
        while (cyc < c) begin
            @(negedge CLK);
            check($sformatf("enable@%0d", cyc), ENABLE,
                  (cyc >= SCAN_DIV) && (cyc % SCAN_DIV == 0));
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) check({e.tag, "_missed"}, cyc, e.cyc);
                else check(e.tag, {L1, L2, L3, L4, OVR_BUSY, OVR_ACK}, {e.l, e.busy, e.ack});
            end
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        BASE_BCD   = '0;
        BASE_DP    = '0;
        BLINK_MASK = '0;
        OVR_REQ    = 1'b0;
        OVR_BCD    = '0;
        repeat (3) @(negedge CLK);
        check("rst_L", {L1, L2, L3, L4}, 32'hFFFF_FFFF);
        check("rst_flags", {OVR_BUSY, OVR_ACK, ENABLE}, 3'b000);

        // Release at a falling edge: the next rising edge is cycle 1.
        RST_N    = 1'b1;
        BASE_BCD = 16'h1208;
        BASE_DP  = 4'b0100;
        expect_at(1, "base_1208", 32'hF924_C080, 1'b0, 1'b0);
        tick_to(1);

        // L4 blinks with an 8-cycle half-period; L1..L3 hold.
        BLINK_MASK = 4'b0001;
        expect_at(9,  "blink_lit9",   32'hF924_C080, 1'b0, 1'b0);
        expect_at(10, "blink_dark10", 32'hF924_C0FF, 1'b0, 1'b0);
        expect_at(17, "blink_dark17", 32'hF924_C0FF, 1'b0, 1'b0);
        expect_at(18, "blink_lit18",  32'hF924_C080, 1'b0, 1'b0);
        tick_to(20);

        // Overlay ABCD: three blink ticks (cycles 24, 32, 40), expiry at 41.
        OVR_REQ = 1'b1;
        OVR_BCD = 16'hABCD;
        expect_at(21, "ovr1_ack",    base_exp(16'h1208, 4'b0100, 4'b0001, phase_vis(21)), 1'b1, 1'b1);
        expect_at(22, "ovr1_show",   32'h8883_C6A1, 1'b1, 1'b0);
        expect_at(30, "ovr1_noblink", 32'h8883_C6A1, 1'b1, 1'b0);
        expect_at(41, "ovr1_expiry", 32'h8883_C6A1, 1'b1, 1'b0);
        expect_at(42, "ovr1_drop",   32'h8883_C6A1, 1'b0, 1'b0);
        expect_at(43, "ovr1_base",   32'hF924_C0FF, 1'b0, 1'b0);
        tick_to(21);
        OVR_REQ = 1'b0;
        OVR_BCD = 16'h0000;
        tick_to(50);

        // Overlay 5A70, re-requested with 0F0F after two ticks.
        OVR_REQ = 1'b1;
        OVR_BCD = 16'h5A70;
        expect_at(51, "ovr2_ack",  32'hF924_C080, 1'b1, 1'b1);
        expect_at(52, "ovr2_show", ovr_exp(16'h5A70), 1'b1, 1'b0);
        expect_at(65, "ovr2_hold", ovr_exp(16'h5A70), 1'b1, 1'b0);
        tick_to(51);
        OVR_REQ = 1'b0;
        OVR_BCD = 16'h1111;
        tick_to(66);
        OVR_REQ = 1'b1;
        OVR_BCD = 16'h0F0F;
        expect_at(67, "ovr3_ack",    ovr_exp(16'h5A70), 1'b1, 1'b1);
        expect_at(68, "ovr3_show",   32'hC08E_C08E, 1'b1, 1'b0);
        expect_at(88, "ovr3_held",   32'hC08E_C08E, 1'b1, 1'b0);
        expect_at(89, "ovr3_expiry", 32'hC08E_C08E, 1'b1, 1'b0);
        expect_at(90, "ovr3_reack",  32'hC08E_C08E, 1'b1, 1'b1);
        tick_to(67);
        OVR_REQ = 1'b0;
        OVR_BCD = 16'h2222;
        tick_to(89);
        // Request in the expiry cycle keeps the overlay up.
        OVR_REQ = 1'b1;
        OVR_BCD = 16'h0F0F;
        tick_to(90);
        OVR_REQ = 1'b0;
        OVR_BCD = 16'h3333;
        tick_to(112);

        // Request coinciding with a blink tick while hold=1 reloads hold to 3.
        OVR_REQ = 1'b1;
        OVR_BCD = 16'hC0DE;
        expect_at(113, "ovr4_ack",    32'hC08E_C08E, 1'b1, 1'b1);
        expect_at(114, "ovr4_show",   32'hC6C0_A186, 1'b1, 1'b0);
        expect_at(137, "ovr4_expiry", 32'hC6C0_A186, 1'b1, 1'b0);
        expect_at(138, "ovr4_drop",   32'hC6C0_A186, 1'b0, 1'b0);
        expect_at(139, "ovr4_base",   base_exp(16'h1208, 4'b0100, 4'b0001, phase_vis(139)), 1'b0, 1'b0);
        tick_to(113);
        OVR_REQ = 1'b0;
        tick_to(150);

        // Reset in the middle of an overlay.
        OVR_REQ = 1'b1;
        OVR_BCD = 16'h3690;
        expect_at(152, "ovr5_show", 32'hB082_90C0, 1'b1, 1'b0);
        tick_to(151);
        OVR_REQ = 1'b0;
        tick_to(155);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_L", {L1, L2, L3, L4}, 32'hFFFF_FFFF);
        check("midrst_flags", {OVR_BUSY, OVR_ACK, ENABLE}, 3'b000);
        check("sb_drained_pre", sb.size(), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        expect_at(1, "postrst_base", 32'hF924_C080, 1'b0, 1'b0);
        tick_to(2);

        // Leading zeros (blanked only when LZ_BLANK_EN is defined).
        BASE_BCD   = 16'h0045;
        BASE_DP    = 4'b0000;
        BLINK_MASK = 4'b0000;
        expect_at(3, "lz_0045", base_exp(16'h0045, 4'b0000, 4'b0000, 1'b0), 1'b0, 1'b0);
        tick_to(4);
        BASE_BCD = 16'h0000;
        expect_at(5, "lz_0000", base_exp(16'h0000, 4'b0000, 4'b0000, 1'b0), 1'b0, 1'b0);
        tick_to(6);
        BASE_BCD = 16'h0045;
        BASE_DP  = 4'b0100;
        expect_at(7, "lz_dp_stop", base_exp(16'h0045, 4'b0100, 4'b0000, 1'b0), 1'b0, 1'b0);
        tick_to(8);
        BASE_BCD = 16'h0105;
        BASE_DP  = 4'b0000;
        expect_at(9, "lz_inner_zero", base_exp(16'h0105, 4'b0000, 4'b0000, 1'b0), 1'b0, 1'b0);
        tick_to(12);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Controller for the 4-digit multiplexed 7-segment scanner (the DCOUNT display mux).
- Generates the scan-enable tick that steps the mux.
- Arbitrates between a base display source (counter value) and a timed overlay source (status/message).
- Encodes the selected BCD digits to active-low segment bytes L1..L4, with per-digit blinking and decimal points.

Parameters:
- SCAN_DIV, 50000: CLK cycles per ENABLE pulse; must be ≥2.
- BLINK_DIV, 64: ENABLE pulses per blink half-period; must be ≥1.
- HOLD_TICKS, 6: blink half-periods an overlay stays visible; must be ≥1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- BASE_BCD  in  16  base digits; [15:12]→L1 (leftmost) … [3:0]→L4.
- BASE_DP  in  4  base decimal points; [3]→L1 … [0]→L4; 1 = lit.
- BLINK_MASK  in  4  base digits to blink; [3]→L1 … [0]→L4.
- OVR_REQ  in  1  overlay request, sampled every cycle.
- OVR_BCD  in  16  overlay digits, captured when the request is accepted.
- OVR_ACK  out  1  one-cycle pulse: request accepted.
- OVR_BUSY  out  1  high while the overlay is displayed.
- ENABLE  out  1  one-cycle scan tick to the mux.
- L1, L2, L3, L4  out  8 each  segment bytes {DP,G,F,E,D,C,B,A}, active-low.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset values: ENABLE=0, OVR_ACK=0, OVR_BUSY=0, L1..L4=8'hFF. Prescaler, blink counter and hold counter = 0. blink_phase=0. State = S_BASE.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. ENABLE is registered high for exactly the cycle after the count equals SCAN_DIV-1. First pulse occurs SCAN_DIV cycles after reset release.
- Blink counter: advances on each ENABLE, range 0..BLINK_DIV-1. On wrap, blink_phase toggles and blink_tick pulses internally for one cycle.
- FSM, two states:
  - S_BASE: if OVR_REQ=1, capture OVR_BCD, load hold=HOLD_TICKS, pulse OVR_ACK next cycle, go to S_OVR.
  - S_OVR: OVR_BUSY=1. Each blink_tick decrements hold. When hold reaches 0 with no request that cycle, go to S_BASE; OVR_BUSY drops in the same cycle as the state change.
  - OVR_REQ in S_OVR: re-capture OVR_BCD, reload hold, pulse OVR_ACK. The request wins over a simultaneous blink_tick or expiry.
  - A held-high OVR_REQ re-acks every cycle; requesters pulse it.
- Decode: digit 0-9 maps to numerals; 10-15 map to hex glyphs A b C d E F.
  - Active-low codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - A lit DP clears bit 7.
- Base output: digit i with BLINK_MASK[i]=1 and blink_phase=1 outputs 8'hFF, including its DP.
- Overlay output: blink is ignored and all DPs are off.
- Latency: L1..L4 are registered, one cycle after inputs or state change. The blink effect is one cycle after the phase toggle.
- Reset mid-overlay: reset values immediately; the overlay is lost.

Optional Feature:
- Macro LZ_BLANK_EN.
- Defined: in S_BASE only, leading zero digits of L1..L3 whose DP is off output 8'hFF. Blanking stops at the first nonzero digit or the first lit DP. L4 is never blanked.
- Undefined: zeros are always displayed.
- The overlay path is unaffected either way.

Decomposition:
- Package disp_pkg: state enum {S_BASE, S_OVR}, SEG_BLANK=8'hFF, 16-entry glyph constant table, DP bit index 7.
- One sub-module: seg7_enc, combinational: 4-bit digit + dp in, 8-bit active-low segments out. Instantiated four times.

Test Plan:
All scenarios use SCAN_DIV=4, BLINK_DIV=2, HOLD_TICKS=3.
1. Reset, release at t0 → L=FF, ENABLE pulses at t0+4, t0+8, …, each exactly one cycle wide.
2. BASE_BCD=16'h1208, BASE_DP=4'b0100 → next cycle L1=F9, L2=24, L3=C0, L4=80.
3. BLINK_MASK=4'b0001, BASE_BCD=16'h1208 → L4 alternates 80/FF every 8 cycles; L1..L3 stay steady.
4. OVR_REQ pulse with OVR_BCD=16'hABCD → OVR_ACK next cycle; L=88,83,C6,A1, OVR_BUSY=1; after 3 blink_ticks, state returns to base and shows 1208.
5. Second OVR_REQ (16'h0F0F) after 2 blink_ticks, repeated in the expiry cycle → new data shown, hold reloaded to 3, no fall back to base.
6. RST_N low mid-overlay → OVR_BUSY=0, L=FF at once; after release, state is S_BASE.
With LZ_BLANK_EN defined: BASE_BCD=16'h0045, DP=0 → L1=L2=FF, L3=99, L4=92. BASE_BCD=16'h0000 → L4=C0 only.
